dm_lsu: RTL and testbench

//  Load/store unit: the requester side of the data-memory port. Accepts one core load/store
//  at a time via valid/ready and drives the dm byte-addressed port (addr, DataWr, DMWr, DMCtrl).

---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_lsu_if.sv | 27 ++
 rtl/load_ext.sv | 19 +
 rtl/dm_lsu.sv | 149 ++++++++++++++
 tb/tb_dm_lsu.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared data-memory types: DMCtrl access encodings, LSU states and access size helper.
package dm_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } lsu_state_e;

  // Illegal encodings report 1; they are rejected before the size matters.
  function automatic logic [2:0] size_of(dm_ctrl_e c);
    case (c)
      DM_H, DM_HU: return 3'd2;
      DM_W:        return 3'd4;
      default:     return 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Core-side request/response handshake plus the byte-addressed dm port of the LSU.
interface dm_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_wr;
  logic [2:0]  dm_ctrl;
  logic [31:0] dm_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, dm_addr, dm_wdata, dm_wr, dm_ctrl
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, dm_addr, dm_wdata, dm_wr, dm_ctrl
  );
endinterface

// File: rtl/load_ext.sv
// Sign/zero extension of a raw load word according to the access type.
module load_ext
  import dm_pkg::*;
(
  input  logic [31:0] raw_i,
  input  dm_ctrl_e    ctrl_i,
  output logic [31:0] ext_o
);
  always_comb begin
    ext_o = raw_i;
    case (ctrl_i)
      DM_B:    ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      DM_H:    ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      DM_BU:   ext_o = {24'b0, raw_i[7:0]};
      DM_HU:   ext_o = {16'b0, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end
endmodule

// File: rtl/dm_lsu.sv
// Load/store unit: one core op at a time, aligned ops in one dm beat, misaligned H/W
// split into ascending byte beats with load bytes reassembled and extended.
module dm_lsu
  import dm_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT       = 8192,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  dm_lsu_if.slave bus
);
  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  dm_ctrl_e    ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        split_q, split_d;
  logic [1:0]  beat_q, beat_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] lanes_q, lanes_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_misal;
  logic        req_err;
  logic [31:0] lanes_cur;
  logic [31:0] ext_word;

  // 33-bit end address so a wrap past 0xFFFFFFFF is caught as out of range.
  always_comb begin
    req_size  = size_of(dm_ctrl_e'(bus.req_funct3));
    req_end   = {1'b0, bus.req_addr} + {30'b0, req_size} - 33'd1;
    req_misal = ((req_size == 3'd2) && bus.req_addr[0]) ||
                ((req_size == 3'd4) && (bus.req_addr[1:0] != 2'b00));
    req_err   = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) ||
                (bus.req_we && !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010})) ||
                (req_end >= 33'(ADDR_LIMIT)) ||
                (req_misal && !SPLIT_MISALIGNED);
  end

  // Current beat's byte merged into the assembly register, so the final beat can extend in place.
  always_comb begin
    lanes_cur = lanes_q;
    lanes_cur[{beat_q, 3'b000} +: 8] = bus.dm_rdata[7:0];
  end

  load_ext u_load_ext (
    .raw_i  (lanes_cur),
    .ctrl_i (ctrl_q),
    .ext_o  (ext_word)
  );

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    ctrl_d        = ctrl_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    split_d       = split_q;
    beat_d        = beat_q;
    last_d        = last_q;
    lanes_d       = lanes_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.dm_addr   = 32'b0;
    bus.dm_wdata  = 32'b0;
    bus.dm_wr     = 1'b0;
    bus.dm_ctrl   = 3'b000;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          ctrl_d  = dm_ctrl_e'(bus.req_funct3);
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = 32'b0;
          err_d   = req_err;
          beat_d  = 2'd0;
          lanes_d = 32'b0;
          split_d = req_misal;
          last_d  = req_misal ? 2'(req_size - 3'd1) : 2'd0;
          state_d = req_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        if (split_q) begin
          bus.dm_addr  = addr_q + {30'b0, beat_q};
          bus.dm_ctrl  = we_q ? DM_B : DM_BU;
          bus.dm_wdata = {24'b0, wdata_q[{beat_q, 3'b000} +: 8]};
          lanes_d      = lanes_cur;
        end else begin
          bus.dm_addr  = addr_q;
          bus.dm_ctrl  = ctrl_q;
          bus.dm_wdata = wdata_q;
        end
        // Gated by reset so an abandoned store does not land one more byte on the reset edge.
        bus.dm_wr = we_q && rst_n;
        beat_d    = beat_q + 2'd1;
        if (beat_q == last_q) begin
          state_d = RESP;
          if (!we_q) rdata_d = split_q ? ext_word : bus.dm_rdata;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ctrl_q  <= DM_B;
      addr_q  <= 32'b0;
      wdata_q <= 32'b0;
      split_q <= 1'b0;
      beat_q  <= 2'd0;
      last_q  <= 2'd0;
      lanes_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      split_q <= split_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      lanes_q <= lanes_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_dm_lsu.sv
// Scoreboard bench for dm_lsu against a byte-addressed dm model; second instance covers SPLIT=0.
module tb_dm_lsu;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, rst1_n, mem_clr;
  int total = 0;
  int bad   = 0;

  dm_lsu_if bus0 ();
  dm_lsu_if bus1 ();

  dm_lsu #(.ADDR_LIMIT(8192), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0)
  );
  dm_lsu #(.ADDR_LIMIT(8192), .SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .rst_n(rst1_n), .bus(bus1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // dm model: combinational read with DMCtrl extension, posedge write
  logic [7:0]  mem [0:8191];
  logic [7:0]  ref_mem [0:8191];
  logic [12:0] ra;
  logic [31:0] rw;
  always_comb begin
    ra = bus0.dm_addr[12:0];
    rw = {mem[ra + 13'd3], mem[ra + 13'd2], mem[ra + 13'd1], mem[ra]};
    case (bus0.dm_ctrl)
      3'b000:  bus0.dm_rdata = {{24{rw[7]}}, rw[7:0]};
      3'b001:  bus0.dm_rdata = {{16{rw[15]}}, rw[15:0]};
      3'b100:  bus0.dm_rdata = {24'b0, rw[7:0]};
      3'b101:  bus0.dm_rdata = {16'b0, rw[15:0]};
      default: bus0.dm_rdata = rw;
    endcase
  end
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    end else if (bus0.dm_wr) begin
      mem[ra] <= bus0.dm_wdata[7:0];
      if (bus0.dm_ctrl == 3'b001 || bus0.dm_ctrl == 3'b010) mem[ra + 13'd1] <= bus0.dm_wdata[15:8];
      if (bus0.dm_ctrl == 3'b010) begin
        mem[ra + 13'd2] <= bus0.dm_wdata[23:16];
        mem[ra + 13'd3] <= bus0.dm_wdata[31:24];
      end
    end
  end
  assign bus1.dm_rdata = bus1.dm_addr ^ 32'hA5A50000;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;
  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;
  exp_t sb[$];
  wr_t  wr_log[$];
  int   cyc_n = 0;
  int   acc_cyc = 0;
  int   beats1 = 0;

  always @(negedge clk) begin
    exp_t e;
    cyc_n++;
    if (bus0.req_valid && bus0.req_ready) acc_cyc = cyc_n;
    if (bus0.dm_wr) wr_log.push_back('{bus0.dm_addr, bus0.dm_wdata[7:0]});
    if (bus1.dm_wr || bus1.dm_addr != 0 || bus1.dm_ctrl != 0 || bus1.dm_wdata != 0) beats1++;
    if (bus0.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        $display("rsp %s rdata=%h err=%0b lat=%0d", e.tag, bus0.rsp_rdata, bus0.rsp_err, cyc_n - acc_cyc);
        chk({e.tag, ".rdata"}, bus0.rsp_rdata, e.rdata);
        chk({e.tag, ".err"}, 32'(bus0.rsp_err), 32'(e.err));
        chk({e.tag, ".lat"}, 32'(cyc_n - acc_cyc), 32'(e.lat));
      end
    end
  end

  function automatic int tb_size(input logic [2:0] f3);
    if (f3 == 3'b010) return 4;
    if (f3 == 3'b001 || f3 == 3'b101) return 2;
    return 1;
  endfunction

  function automatic int tb_lat(input logic [2:0] f3, input logic [31:0] addr);
    int n = tb_size(f3);
    if ((n == 2 && addr[0]) || (n == 4 && addr[1:0] != 0)) return n + 1;
    return 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    logic [31:0] v = 0;
    int n = tb_size(f3);
    for (int k = 0; k < n; k++) v[8*k +: 8] = ref_mem[(addr + k) & 32'h1FFF];
    case (f3)
      3'b000:  return {{24{v[7]}}, v[7:0]};
      3'b001:  return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    for (int k = 0; k < tb_size(f3); k++) ref_mem[(addr + k) & 32'h1FFF] = wd[8*k +: 8];
  endtask

  task automatic op(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                    input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                    input int exp_lat, input string tag);
    int n;
    sb.push_back('{exp_rd, exp_err, exp_lat, tag});
    @(posedge clk); #1;
    n = 0;
    while (!bus0.req_ready && n < 20) begin @(posedge clk); #1; n++; end
    bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
    bus0.req_addr = addr; bus0.req_wdata = wd;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, ".drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd, input string tag);
    op(1'b1, f3, addr, wd, 32'd0, 1'b0, tb_lat(f3, addr), tag);
    model_store(f3, addr, wd);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp, input string tag);
    op(1'b0, f3, addr, 32'd0, exp, 1'b0, tb_lat(f3, addr), tag);
  endtask

  task automatic bad_op(input bit we, input logic [2:0] f3, input logic [31:0] addr, input string tag);
    wr_log.delete();
    op(we, f3, addr, 32'hFFFFFFFF, 32'd0, 1'b1, 1, tag);
    chk({tag, ".wr_beats"}, 32'(wr_log.size()), 32'd0);
  endtask

  initial begin
    logic [2:0] f3s [5];
    logic [31:0] exp_bytes [4];
    int acc_list[$];
    logic [2:0] f3;
    logic [31:0] a;
    bit we;
    f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    exp_bytes = '{32'hEF, 32'hBE, 32'hAD, 32'hDE};
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'h00;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_funct3 = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_funct3 = 0; bus1.req_addr = 0; bus1.req_wdata = 0;
    rst_n = 0; rst1_n = 0; mem_clr = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1; rst1_n = 1; mem_clr = 0;
    @(negedge clk);
    chk("rst.ready", 32'(bus0.req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rst.rsp_err", 32'(bus0.rsp_err), 32'd0);
    chk("rst.rsp_rdata", bus0.rsp_rdata, 32'd0);
    chk("rst.dm_wr", 32'(bus0.dm_wr), 32'd0);
    chk("rst.dm_addr", bus0.dm_addr, 32'd0);

    wr_log.delete();
    st(3'b010, 32'h10, 32'h12345678, "sw_10");
    chk("sw_10.wr_beats", 32'(wr_log.size()), 32'd1);
    ld(3'b010, 32'h10, 32'h12345678, "lw_10");

    wr_log.delete();
    st(3'b010, 32'h5, 32'hDEADBEEF, "sw_5");
    chk("sw_5.wr_beats", 32'(wr_log.size()), 32'd4);
    for (int k = 0; k < 4 && k < wr_log.size(); k++) begin
      chk($sformatf("sw_5.beat%0d.addr", k), wr_log[k].a, 32'h5 + k);
      chk($sformatf("sw_5.beat%0d.data", k), 32'(wr_log[k].d), exp_bytes[k]);
    end
    op(1'b0, 3'b010, 32'h5, 32'd0, 32'hDEADBEEF, 1'b0, 5, "lw_5");
    ld(3'b010, 32'h4, 32'hADBEEF00, "lw_4");
    op(1'b0, 3'b001, 32'h7, 32'd0, 32'hFFFFDEAD, 1'b0, 3, "lh_7");
    ld(3'b101, 32'h7, 32'h0000DEAD, "lhu_7");
    ld(3'b000, 32'h8, 32'hFFFFFFDE, "lb_8");

    bad_op(1'b0, 3'b010, 32'h1FFE, "lw_1ffe");
    bad_op(1'b1, 3'b010, 32'hFFFFFFFF, "sw_ffffffff");
    bad_op(1'b1, 3'b100, 32'h20, "st_f3_100");
    bad_op(1'b0, 3'b011, 32'h20, "ld_f3_011");
    ld(3'b010, 32'h1FFC, model_load(3'b010, 32'h1FFC), "lw_1ffc");

    for (int i = 0; i < 16; i++) begin
      we = 1'(($urandom_range(0, 1)));
      f3 = we ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)];
      a  = 32'h100 + $urandom_range(0, 127);
      if (we) st(f3, a, $urandom, $sformatf("rnd%0d_st", i));
      else    ld(f3, a, model_load(f3, a), $sformatf("rnd%0d_ld", i));
    end

    // reset lands during the third byte beat of a split store
    wr_log.delete();
    @(posedge clk); #1;
    bus0.req_valid = 1; bus0.req_we = 1; bus0.req_funct3 = 3'b010;
    bus0.req_addr = 32'h21; bus0.req_wdata = 32'hAABBCCDD;
    @(posedge clk); #1 bus0.req_valid = 0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    chk("rstmid.ready", 32'(bus0.req_ready), 32'd1);
    chk("rstmid.rsp_valid", 32'(bus0.rsp_valid), 32'd0);
    chk("rstmid.dm_wr", 32'(bus0.dm_wr), 32'd0);
    chk("rstmid.wr_beats", 32'(wr_log.size()), 32'd2);
    ref_mem[32'h21] = 8'hDD; ref_mem[32'h22] = 8'hCC;
    for (int k = 32'h21; k <= 32'h24; k++)
      chk($sformatf("rstmid.mem%0h", k), 32'(mem[k]), 32'(ref_mem[k]));
    $display("op rstmid sw @21 abandoned after 2 beats");

    // SPLIT_MISALIGNED=0 instance
    @(posedge clk); #1;
    beats1 = 0;
    bus1.req_valid = 1; bus1.req_we = 0; bus1.req_funct3 = 3'b001; bus1.req_addr = 32'h3;
    @(negedge clk);
    chk("ns_lh3.accept", 32'(bus1.req_ready), 32'd1);
    @(posedge clk); #1 bus1.req_valid = 0;
    @(negedge clk);
    $display("rsp ns_lh3 rdata=%h err=%0b", bus1.rsp_rdata, bus1.rsp_err);
    chk("ns_lh3.valid", 32'(bus1.rsp_valid), 32'd1);
    chk("ns_lh3.err", 32'(bus1.rsp_err), 32'd1);
    chk("ns_lh3.rdata", bus1.rsp_rdata, 32'd0);
    chk("ns_lh3.beats", 32'(beats1), 32'd0);

    @(posedge clk); #1;
    bus1.req_valid = 1; bus1.req_we = 0; bus1.req_funct3 = 3'b010; bus1.req_addr = 32'h10;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus1.req_valid && bus1.req_ready) acc_list.push_back(i);
      if (bus1.rsp_valid) begin
        $display("rsp ns_b2b rdata=%h err=%0b", bus1.rsp_rdata, bus1.rsp_err);
        chk("ns_b2b.rdata", bus1.rsp_rdata, 32'hA5A50010);
        chk("ns_b2b.err", 32'(bus1.rsp_err), 32'd0);
      end
    end
    #1 bus1.req_valid = 0;
    chk("ns_b2b.accepts", 32'(acc_list.size()), 32'd4);
    for (int i = 1; i < acc_list.size(); i++)
      chk($sformatf("ns_b2b.gap%0d", i), 32'(acc_list[i] - acc_list[i-1]), 32'd3);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
